// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - RV32I funct3 width/sign codes for loads and stores
//   - FSM state encoding (IDLE / ACCESS / MERGE_WR)
//   - legality and alignment helpers used when a request is accepted
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2
  } lsu_state_e;

  // Stores only exist in signed-width form; loads add the unsigned variants.
  function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) begin
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  // Only meaningful for legal codes: low two funct3 bits give the access size.
  function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return (lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: combinational little-endian lane steering.
//   funct3      : width/sign code of the access
//   addr_lo     : byte offset within the word (halfwords use bit 1 only)
//   rd_word     : word read from memory
//   st_data     : right-aligned store data from the core
//   load_val    : selected lane, sign- or zero-extended
//   store_word  : rd_word with the addressed lane(s) replaced (whole st_data for words)
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rd_word,
  input  logic [31:0] st_data,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  always_comb begin
    rd_byte = rd_word[{addr_lo, 3'b000} +: 8];
    rd_half = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{rd_byte[7]}}, rd_byte};
      F3_BU:   load_val = {24'h000000, rd_byte};
      F3_H:    load_val = {{16{rd_half[15]}}, rd_half};
      F3_HU:   load_val = {16'h0000, rd_half};
      default: load_val = rd_word;
    endcase

    // Bytes outside the addressed lane keep what memory returned.
    store_word = rd_word;
    case (funct3)
      F3_B:    store_word[{addr_lo, 3'b000} +: 8]   = st_data[7:0];
      F3_H:    store_word[{addr_lo[1], 4'b0000} +: 16] = st_data[15:0];
      default: store_word = st_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32I byte/half/word loads and stores on a word-only memory.
//   Core side : req/ready handshake, we, funct3, addr, wdata in;
//               done/err one-cycle pulses and rdata out.
//   Memory    : mem_read / mem_write strobes, word-aligned mem_address,
//               mem_write_data, combinational mem_read_data.
//   Sub-word stores read the word in ACCESS and write the merged word in MERGE_WR.
//   Optional: define MISALIGN_TRAP_EN to reject misaligned half/word accesses
//   with err instead of silently ignoring the low address bits.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  output logic              ready,
  input  logic              we,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              bad_q, bad_d;      // request is rejected: no strobes, err at done
  logic [DATA_W-1:0] merged_q, merged_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] load_val;
  logic [DATA_W-1:0] store_word;
  logic              misalign;
  logic              is_sw;
  logic              is_rmw;

  lsu_lane_align u_align (
    .funct3     (funct3_q),
    .addr_lo    (addr_q[1:0]),
    .rd_word    (mem_read_data),
    .st_data    (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  // bad_q already excludes illegal codes, so a legal non-word store is SB/SH.
  assign is_sw  = we_q && (funct3_q == F3_W);
  assign is_rmw = we_q && (funct3_q != F3_W);

  always_comb begin
    misalign = 1'b0;
`ifdef MISALIGN_TRAP_EN
    misalign = addr_misaligned(funct3, addr[1:0]);
`endif
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    bad_d    = bad_q;
    merged_d = merged_q;
    rdata_d  = rdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          we_d     = we;
          funct3_d = funct3;
          addr_d   = addr;
          wdata_d  = wdata;
          bad_d    = !funct3_legal(we, funct3) || misalign;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (bad_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else if (is_rmw) begin
          merged_d = store_word;
          state_d  = MERGE_WR;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
          if (!we_q) begin
            rdata_d = load_val;
          end
        end
      end
      MERGE_WR: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      bad_q    <= 1'b0;
      merged_q <= '0;
      rdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      bad_q    <= bad_d;
      merged_q <= merged_d;
      rdata_q  <= rdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Memory side depends only on state and latched fields.
  always_comb begin
    mem_read       = (state_q == ACCESS) && !bad_q && !is_sw;
    mem_write      = ((state_q == ACCESS) && !bad_q && is_sw) || (state_q == MERGE_WR);
    mem_address    = {addr_q[ADDR_W-1:2], 2'b00};
    mem_write_data = '0;
    if (state_q == MERGE_WR) begin
      mem_write_data = merged_q;
    end else if ((state_q == ACCESS) && !bad_q && is_sw) begin
      mem_write_data = wdata_q;
    end
  end

  assign ready = (state_q == IDLE);
  assign done  = done_q;
  assign err   = err_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a word memory model.
module tb_load_store_unit;

  localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        ready;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        done, err;
  logic [31:0] rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst), .req(req), .ready(ready), .we(we), .funct3(funct3),
    .addr(addr), .wdata(wdata), .done(done), .err(err), .rdata(rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  always #5 clk = ~clk;

  // Word memory model, no reset; bench preloads through the poke port.
  logic [31:0] mem [0:1023];
  logic        pre_en = 1'b0;
  logic [9:0]  pre_idx = 10'd0;
  logic [31:0] pre_val = 32'h0;
  assign mem_read_data = mem[mem_address[11:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[11:2]] <= mem_write_data;
    else if (pre_en) mem[pre_idx] <= pre_val;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  always @(posedge clk) cyc++;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rdn;
    int          wrn;
    logic        chkr;
    int          acc;
    int          rd0;
    int          wr0;
  } exp_t;
  exp_t  sb_q[$];
  string tag_q[$];

  // Monitor: count strobes and retire scoreboard entries on done.
  always @(negedge clk) begin
    exp_t  e;
    string t;
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (!done) check_val("err_without_done", 32'(err), 32'd0);
    if (done) begin
      if (sb_q.size() == 0) begin
        check_val("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        check_val({t, " err"}, 32'(err), 32'(e.err));
        check_val({t, " latency"}, 32'(cyc - e.acc + 1), 32'(e.lat));
        check_val({t, " mem_read_cycles"}, 32'(rd_cnt - e.rd0), 32'(e.rdn));
        check_val({t, " mem_write_cycles"}, 32'(wr_cnt - e.wr0), 32'(e.wrn));
        if (e.chkr) check_val({t, " rdata"}, rdata, e.rdata);
        $display("txn %s done at cycle %0d err=%0b rdata=%08h", t, cyc, err, rdata);
      end
    end
  end

  task automatic do_op(input string tag, input logic w, input logic [2:0] f,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] er, input logic ee, input int lat,
                       input int rdn, input int wrn, input logic chkr, output int acc);
    exp_t e;
    int   n;
    @(negedge clk);
    req = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
    n = 0;
    while (!ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, " ready_for_accept"}, 32'(ready), 32'd1);
    @(posedge clk);
    #1;
    acc = cyc;
    e.rdata = er; e.err = ee; e.lat = lat; e.rdn = rdn; e.wrn = wrn; e.chkr = chkr;
    e.acc = acc; e.rd0 = rd_cnt; e.wr0 = wr_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    // Scramble inputs so any late sampling of the core bus shows up.
    req = 1'b0; we = ~w; funct3 = 3'b111; addr = $urandom; wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    check_val("drain_pending", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic poke(input logic [9:0] idx, input logic [31:0] val);
    @(negedge clk);
    pre_en = 1'b1; pre_idx = idx; pre_val = val;
    @(posedge clk);
    #1;
    pre_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a1, a2, ax;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("reset ready", 32'(ready), 32'd1);
    check_val("reset done_err", {30'd0, done, err}, 32'd0);
    check_val("reset rdata", rdata, 32'h0);
    check_val("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check_val("reset mem_address", mem_address, 32'h0);
    check_val("reset mem_write_data", mem_write_data, 32'h0);

    do_op("SW 0x10", 1'b1, W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 0, 1, 1'b0, ax);
    do_op("LW 0x10", 1'b0, W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1, 0, 1'b1, ax);
    drain();
    check_val("mem 0x10 after SW", mem[4], 32'hDEADBEEF);

    poke(10'd4, 32'h8899AABB);
    poke(10'd8, 32'h0000F080);
    do_op("SB 0x12", 1'b1, B, 32'h12, 32'hCAFE1255, 32'h0, 1'b0, 3, 1, 1, 1'b0, ax);
    drain();
    check_val("mem 0x10 after SB", mem[4], 32'h8855AABB);

    do_op("LB 0x20",  1'b0, B,  32'h20, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1, 0, 1'b1, ax);
    do_op("LBU 0x20", 1'b0, BU, 32'h20, 32'h0, 32'h00000080, 1'b0, 2, 1, 0, 1'b1, ax);
    do_op("LH 0x20",  1'b0, H,  32'h20, 32'h0, 32'hFFFFF080, 1'b0, 2, 1, 0, 1'b1, ax);
    do_op("LHU 0x22", 1'b0, HU, 32'h22, 32'h0, 32'h00000000, 1'b0, 2, 1, 0, 1'b1, ax);
    do_op("LB 0x21",  1'b0, B,  32'h21, 32'h0, 32'hFFFFFFF0, 1'b0, 2, 1, 0, 1'b1, ax);
    do_op("SH 0x22",  1'b1, H,  32'h22, 32'h1234BEEF, 32'h0, 1'b0, 3, 1, 1, 1'b0, ax);
    drain();
    check_val("mem 0x20 after SH", mem[8], 32'hBEEFF080);
    do_op("LH 0x22", 1'b0, H, 32'h22, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1, 0, 1'b1, ax);

    do_op("load f3=011", 1'b0, 3'b011, 32'h10, 32'h0, 32'hFFFFBEEF, 1'b1, 2, 0, 0, 1'b1, ax);
    do_op("store f3=100", 1'b1, 3'b100, 32'h10, 32'h77, 32'hFFFFBEEF, 1'b1, 2, 0, 0, 1'b1, ax);
`ifdef MISALIGN_TRAP_EN
    do_op("LW 0x13 trap", 1'b0, W, 32'h13, 32'h0, 32'hFFFFBEEF, 1'b1, 2, 0, 0, 1'b1, ax);
    do_op("SH 0x21 trap", 1'b1, H, 32'h21, 32'h1, 32'hFFFFBEEF, 1'b1, 2, 0, 0, 1'b1, ax);
`else
    do_op("LW 0x13", 1'b0, W, 32'h13, 32'h0, 32'h8855AABB, 1'b0, 2, 1, 0, 1'b1, ax);
`endif
    drain();
    check_val("mem 0x10 after rejects", mem[4], 32'h8855AABB);

    do_op("b2b LW 0x10", 1'b0, W, 32'h10, 32'h0, 32'h8855AABB, 1'b0, 2, 1, 0, 1'b1, a1);
    do_op("b2b SW 0x30", 1'b1, W, 32'h30, 32'h12345678, 32'h0, 1'b0, 2, 0, 1, 1'b0, a2);
    check_val("b2b accept spacing", 32'(a2 - a1), 32'd2);
    drain();
    check_val("mem 0x30 after b2b", mem[12], 32'h12345678);

    // Reset lands on the MERGE_WR edge: write commits, no done.
    poke(10'd4, 32'h11223344);
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = B; addr = 32'h11; wdata = 32'h000000A5;
    check_val("rst-sb ready", 32'(ready), 32'd1);
    @(posedge clk);
    #1 req = 1'b0;
    @(negedge clk);
    check_val("rst-sb access read", 32'(mem_read), 32'd1);
    @(negedge clk);
    check_val("rst-sb merge write", 32'(mem_write), 32'd1);
    check_val("rst-sb merge data", mem_write_data, 32'h1122A544);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst-sb ready after", 32'(ready), 32'd1);
    check_val("rst-sb strobes after", {30'd0, mem_read, mem_write}, 32'd0);
    check_val("rst-sb done after", 32'(done), 32'd0);
    check_val("rst-sb mem committed", mem[4], 32'h1122A544);
    repeat (3) @(negedge clk);
    do_op("LW 0x10 post-reset", 1'b0, W, 32'h10, 32'h0, 32'h1122A544, 1'b0, 2, 1, 0, 1'b1, ax);
    drain();
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
